// File: rtl/fpu_pkg.sv
// Shared FPU add/sub datapath definitions.
// Holds the single-precision default widths, the largest biased exponent,
// and the default-width view of the normalisation-stage output beat.
package fpu_pkg;

  localparam int MW_DEF  = 23;
  localparam int EW_DEF  = 8;
  localparam int OB_DEF  = 3;
  localparam int LSW_DEF = 5;

  // All-ones biased exponent: reserved for infinity/NaN.
  localparam int EXP_MAX = (1 << EW_DEF) - 1;

  typedef struct packed {
    logic [MW_DEF-1:0] mant;
    logic [EW_DEF-1:0] exp;
    logic              path_right;
    logic              ovf;
    logic              unf;
  } norm_beat_t;

  // All-ones exponent for an arbitrary exponent width.
  function automatic int exp_max_of(input int ew);
    return (1 << ew) - 1;
  endfunction

endpackage

// File: rtl/msb_index_enc.sv
// Priority encoder: index of the most significant set bit.
// Ports:
//   vec_i   [W-1:0]  input vector
//   idx_o   [IW-1:0] index of the highest set bit (0 when vec_i is zero)
//   valid_o          at least one bit of vec_i is set
module msb_index_enc #(
  parameter int W  = 3,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign valid_o = |vec_i;

endmodule

// File: rtl/mantissa_norm_select_pipe.sv
// Post-adder normalisation select stage for the FPU add/sub datapath.
// Chooses the left- or right-shifted mantissa from the adder overflow bits,
// adjusts the exponent, flags exponent overflow (infinity) and underflow
// (flush to zero), and registers the result behind a valid/ready handshake.
//
// Optional feature macro: MNS_ROUND_BITS_EN adds per-path guard/round/sticky
// inputs (left_grs, right_grs) and a registered grs_out.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   upstream handshake
//   left_path           left-normalised mantissa [MW]
//   right_path          right-normalised mantissa [MW]
//   ovf_bits            adder bits above the hidden bit [OB]
//   exp_in              pre-normalisation exponent [EW]
//   lshift_amt          left-shift count applied to left_path [LSW]
//   out_valid/out_ready downstream handshake
//   mant_out, exp_out   selected mantissa, adjusted exponent
//   path_right          1 = right path taken
//   ovf_flag, unf_flag  exponent overflow / underflow
module mantissa_norm_select_pipe
  import fpu_pkg::*;
#(
  parameter int MW  = MW_DEF,
  parameter int EW  = EW_DEF,
  parameter int OB  = OB_DEF,
  parameter int LSW = LSW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MW-1:0]  left_path,
  input  logic [MW-1:0]  right_path,
  input  logic [OB-1:0]  ovf_bits,
  input  logic [EW-1:0]  exp_in,
  input  logic [LSW-1:0] lshift_amt,
`ifdef MNS_ROUND_BITS_EN
  input  logic [2:0]     left_grs,
  input  logic [2:0]     right_grs,
  output logic [2:0]     grs_out,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MW-1:0]  mant_out,
  output logic [EW-1:0]  exp_out,
  output logic           path_right,
  output logic           ovf_flag,
  output logic           unf_flag
);

  localparam int IW = (OB > 1) ? $clog2(OB) : 1;
  // Two extra bits: one for headroom above EXP_MAX, one for sign below zero.
  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] EXP_MAX_X = XW'(exp_max_of(EW));

  // Parametrised twin of fpu_pkg::norm_beat_t.
  typedef struct packed {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          path_right;
    logic          ovf;
    logic          unf;
`ifdef MNS_ROUND_BITS_EN
    logic [2:0]    grs;
`endif
  } beat_t;

  beat_t beat_d, beat_q;
  logic  valid_q;

  logic [IW-1:0]          msb_idx;
  logic                   any_ovf;
  logic                   choose_left;
  logic                   accept;
  logic signed [XW-1:0]   exp_x;
  logic signed [XW-1:0]   shift_x;
  logic signed [XW-1:0]   rinc_x;
  logic signed [XW-1:0]   e_x;
  logic                   is_ovf;
  logic                   is_unf;

  msb_index_enc #(.W(OB), .IW(IW)) u_msb_enc (
    .vec_i   (ovf_bits),
    .idx_o   (msb_idx),
    .valid_o (any_ovf)
  );

  assign choose_left = ~any_ovf;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Operands are zero-extended so the signed result can go negative
  // instead of wrapping when the left shift exceeds the exponent.
  assign exp_x   = XW'(exp_in);
  assign shift_x = XW'(lshift_amt);
  assign rinc_x  = XW'(msb_idx) + XW'(1);
  assign e_x     = choose_left ? (exp_x - shift_x) : (exp_x + rinc_x);

  assign is_ovf = (e_x >= EXP_MAX_X);
  assign is_unf = e_x[XW-1] | (e_x == '0);

  always_comb begin
    beat_d            = '0;
    beat_d.path_right = ~choose_left;
    beat_d.mant       = choose_left ? left_path : right_path;
    beat_d.exp        = e_x[EW-1:0];
`ifdef MNS_ROUND_BITS_EN
    beat_d.grs        = choose_left ? left_grs : right_grs;
`endif
    if (is_ovf) begin
      beat_d.ovf  = 1'b1;
      beat_d.exp  = '1;
      beat_d.mant = '0;
`ifdef MNS_ROUND_BITS_EN
      beat_d.grs  = '0;
`endif
    end else if (is_unf) begin
      beat_d.unf  = 1'b1;
      beat_d.exp  = '0;
      beat_d.mant = '0;
`ifdef MNS_ROUND_BITS_EN
      beat_d.grs  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      beat_q  <= beat_d;
    end else if (out_ready) begin
      // Drained with nothing new: data holds, only valid drops.
      valid_q <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign mant_out   = beat_q.mant;
  assign exp_out    = beat_q.exp;
  assign path_right = beat_q.path_right;
  assign ovf_flag   = beat_q.ovf;
  assign unf_flag   = beat_q.unf;
`ifdef MNS_ROUND_BITS_EN
  assign grs_out    = beat_q.grs;
`endif

endmodule

// File: tb/tb_mantissa_norm_select_pipe.sv
module tb_mantissa_norm_select_pipe;

  localparam int MW  = 23;
  localparam int EW  = 8;
  localparam int OB  = 3;
  localparam int LSW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [MW-1:0]  left_path;
  logic [MW-1:0]  right_path;
  logic [OB-1:0]  ovf_bits;
  logic [EW-1:0]  exp_in;
  logic [LSW-1:0] lshift_amt;
  logic           out_valid;
  logic           out_ready;
  logic [MW-1:0]  mant_out;
  logic [EW-1:0]  exp_out;
  logic           path_right;
  logic           ovf_flag;
  logic           unf_flag;
`ifdef MNS_ROUND_BITS_EN
  logic [2:0]     left_grs;
  logic [2:0]     right_grs;
  logic [2:0]     grs_out;
`endif

  mantissa_norm_select_pipe #(.MW(MW), .EW(EW), .OB(OB), .LSW(LSW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .left_path  (left_path),
    .right_path (right_path),
    .ovf_bits   (ovf_bits),
    .exp_in     (exp_in),
    .lshift_amt (lshift_amt),
`ifdef MNS_ROUND_BITS_EN
    .left_grs   (left_grs),
    .right_grs  (right_grs),
    .grs_out    (grs_out),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_out   (mant_out),
    .exp_out    (exp_out),
    .path_right (path_right),
    .ovf_flag   (ovf_flag),
    .unf_flag   (unf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OB-1:0]  ovf;
    logic [EW-1:0]  ex;
    logic [LSW-1:0] ls;
    logic [MW-1:0]  lp;
    logic [MW-1:0]  rp;
    logic [2:0]     lg;
    logic [2:0]     rg;
    logic [MW-1:0]  mant;
    logic [EW-1:0]  eexp;
    logic           pr;
    logic           of;
    logic           uf;
    logic [2:0]     grs;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t cur;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_drained = 0;

  function automatic vec_t mk(
    input logic [OB-1:0] ovf, input int ex, input int ls,
    input logic [MW-1:0] lp, input logic [MW-1:0] rp,
    input logic [2:0] lg, input logic [2:0] rg,
    input logic [MW-1:0] mant, input int eexp,
    input logic pr, input logic of, input logic uf, input logic [2:0] grs);
    vec_t v;
    v.ovf = ovf; v.ex = EW'(ex); v.ls = LSW'(ls); v.lp = lp; v.rp = rp;
    v.lg = lg; v.rg = rg; v.mant = mant; v.eexp = EW'(eexp);
    v.pr = pr; v.of = of; v.uf = uf; v.grs = grs;
    return v;
  endfunction

  // Reference behaviour in plain integer arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   e;
    int   sh;
    if (v.ovf == '0) begin
      e = int'(v.ex) - int'(v.ls);
      r.pr = 1'b0; r.mant = v.lp; r.grs = v.lg;
    end else begin
      sh = 0;
      for (int i = 0; i < OB; i++) if (v.ovf[i]) sh = i + 1;
      e = int'(v.ex) + sh;
      r.pr = 1'b1; r.mant = v.rp; r.grs = v.rg;
    end
    r.of = 1'b0; r.uf = 1'b0;
    if (e >= 255) begin
      r.of = 1'b1; r.eexp = 8'hFF; r.mant = '0; r.grs = '0;
    end else if (e <= 0) begin
      r.uf = 1'b1; r.eexp = 8'h00; r.mant = '0; r.grs = '0;
    end else begin
      r.eexp = EW'(e);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cmp_beat(input vec_t e);
    chk("mant_out", 32'(mant_out), 32'(e.mant));
    chk("exp_out", 32'(exp_out), 32'(e.eexp));
    chk("path_right", 32'(path_right), 32'(e.pr));
    chk("ovf_flag", 32'(ovf_flag), 32'(e.of));
    chk("unf_flag", 32'(unf_flag), 32'(e.uf));
`ifdef MNS_ROUND_BITS_EN
    chk("grs_out", 32'(grs_out), 32'(e.grs));
`endif
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in_valid   = vld;
    ovf_bits   = v.ovf;
    exp_in     = v.ex;
    lshift_amt = v.ls;
    left_path  = v.lp;
    right_path = v.rp;
`ifdef MNS_ROUND_BITS_EN
    left_grs   = v.lg;
    right_grs  = v.rg;
`endif
    cur = v;
  endtask

  // Sample handshakes just before the edge: a drain pops and compares,
  // an accept pushes the expected result of the beat being driven.
  task automatic cycle();
    vec_t e;
    #2;
    if (out_valid && out_ready) begin
      n_drained++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got output beat expected none");
      end else begin
        e = sb.pop_front();
        cmp_beat(e);
      end
    end
    if (in_valid && in_ready) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    vec_t va;
    vec_t vb;
    vec_t v;
    int   d0;

    idle = mk(3'b000, 100, 0, '0, '0, 3'b000, 3'b000, '0, 100, 1'b0, 1'b0, 1'b0, 3'b000);

    tbl.push_back(mk(3'b000, 100, 3, 23'h400001, 23'h7FFFFF, 3'b110, 3'b001, 23'h400001, 97, 0, 0, 0, 3'b110));
    tbl.push_back(mk(3'b001, 100, 0, 23'h111111, 23'h123456, 3'b011, 3'b101, 23'h123456, 101, 1, 0, 0, 3'b101));
    tbl.push_back(mk(3'b100, 100, 7, 23'h111111, 23'h234567, 3'b000, 3'b010, 23'h234567, 103, 1, 0, 0, 3'b010));
    tbl.push_back(mk(3'b010, 253, 0, 23'h111111, 23'h345678, 3'b000, 3'b111, 23'h000000, 255, 1, 1, 0, 3'b000));
    tbl.push_back(mk(3'b000, 2, 5, 23'h3FFFFF, 23'h000000, 3'b111, 3'b000, 23'h000000, 0, 0, 0, 1, 3'b000));
    tbl.push_back(mk(3'b000, 0, 0, 23'h155555, 23'h000000, 3'b001, 3'b000, 23'h000000, 0, 0, 0, 1, 3'b000));
    tbl.push_back(mk(3'b000, 10, 20, 23'h2AAAAA, 23'h000000, 3'b000, 3'b000, 23'h000000, 0, 0, 0, 1, 3'b000));
    tbl.push_back(mk(3'b001, 253, 0, 23'h000000, 23'h654321, 3'b000, 3'b100, 23'h654321, 254, 1, 0, 0, 3'b100));
    tbl.push_back(mk(3'b000, 255, 0, 23'h7FFFFF, 23'h000000, 3'b011, 3'b000, 23'h000000, 255, 0, 1, 0, 3'b000));
    tbl.push_back(mk(3'b000, 254, 0, 23'h7FFFFE, 23'h000000, 3'b011, 3'b000, 23'h7FFFFE, 254, 0, 0, 0, 3'b011));
    tbl.push_back(mk(3'b000, 1, 0, 23'h000001, 23'h000000, 3'b100, 3'b000, 23'h000001, 1, 0, 0, 0, 3'b100));
    tbl.push_back(mk(3'b000, 1, 1, 23'h000002, 23'h000000, 3'b000, 3'b000, 23'h000000, 0, 0, 0, 1, 3'b000));
    tbl.push_back(mk(3'b111, 252, 0, 23'h000000, 23'h0ABCDE, 3'b000, 3'b110, 23'h000000, 255, 1, 1, 0, 3'b000));
    tbl.push_back(mk(3'b011, 0, 0, 23'h000000, 23'h0FEDCB, 3'b000, 3'b001, 23'h0FEDCB, 2, 1, 0, 0, 3'b001));
    tbl.push_back(mk(3'b000, 32, 31, 23'h012345, 23'h000000, 3'b101, 3'b000, 23'h012345, 1, 0, 0, 0, 3'b101));

    // Reset state
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(idle, 1'b0);
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mant_out", 32'(mant_out), 32'd0);
    chk("rst_exp_out", 32'(exp_out), 32'd0);
    chk("rst_path_right", 32'(path_right), 32'd0);
    chk("rst_ovf_flag", 32'(ovf_flag), 32'd0);
    chk("rst_unf_flag", 32'(unf_flag), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table, streamed back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], 1'b1);
      cycle();
      if (i == 0) begin
        chk("latency1_out_valid", 32'(out_valid), 32'd1);
        chk("latency1_mant", 32'(mant_out), 32'h400001);
      end
    end
    drive(idle, 1'b0);
    for (int k = 0; k < 5 && sb.size() > 0; k++) cycle();
    chk("table_drain_left", 32'(sb.size()), 32'd0);
    chk("table_drained", 32'(n_drained), 32'(tbl.size()));
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_mant_hold", 32'(mant_out), 32'h012345);

    // Backpressure: A held while B waits, then A drains as B loads
    va = mk(3'b000, 50, 2, 23'h0AAAAA, 23'h000000, 3'b010, 3'b000, 23'h0AAAAA, 48, 0, 0, 0, 3'b010);
    vb = mk(3'b001, 60, 0, 23'h000000, 23'h055555, 3'b000, 3'b011, 23'h055555, 61, 1, 0, 0, 3'b011);
    drive(va, 1'b1);
    cycle();
    drive(vb, 1'b1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_mant", 32'(mant_out), 32'h0AAAAA);
      chk("stall_exp", 32'(exp_out), 32'd48);
    end
    out_ready = 1'b1;
    cycle();
    chk("b2b_out_valid", 32'(out_valid), 32'd1);
    chk("b2b_mant", 32'(mant_out), 32'h055555);
    chk("b2b_path_right", 32'(path_right), 32'd1);
    drive(idle, 1'b0);
    cycle();
    chk("bp_drain_left", 32'(sb.size()), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd0);

    // Random streaming, 8 beats on consecutive cycles
    d0 = n_drained;
    for (int k = 0; k < 8; k++) begin
      v = idle;
      v.ovf = ($urandom_range(0, 1) == 0) ? 3'b000 : OB'($urandom_range(1, 7));
      v.ex  = EW'($urandom_range(0, 255));
      v.ls  = LSW'($urandom_range(0, 31));
      v.lp  = MW'($urandom);
      v.rp  = MW'($urandom);
      v.lg  = 3'($urandom);
      v.rg  = 3'($urandom);
      drive(model(v), 1'b1);
      cycle();
    end
    drive(idle, 1'b0);
    cycle();
    chk("stream_drained", 32'(n_drained - d0), 32'd8);
    chk("stream_left", 32'(sb.size()), 32'd0);

    // Async reset mid-stream discards the held beat
    for (int k = 0; k < 3; k++) begin
      v = idle;
      v.ovf = OB'($urandom_range(1, 3));
      v.ex  = EW'($urandom_range(10, 200));
      v.rp  = MW'($urandom_range(1, 23'h7FFFFF));
      drive(model(v), 1'b1);
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_mant", 32'(mant_out), 32'd0);
    chk("arst_exp", 32'(exp_out), 32'd0);
    chk("arst_path_right", 32'(path_right), 32'd0);
    chk("arst_flags", 32'({ovf_flag, unf_flag}), 32'd0);
    sb.delete();
    drive(idle, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arst_hold_valid", 32'(out_valid), 32'd0);
    drive(tbl[1], 1'b1);
    cycle();
    drive(idle, 1'b0);
    cycle();
    chk("post_rst_left", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
